// File: rtl/prog_loader.sv
// Byte-stream program loader: accepts bytes over valid/ready, shifts them
// LSB-first onto prog_data/prog_enable, then verifies a trailing XOR checksum.
module prog_loader #(
    parameter int unsigned TOTAL_BITS = 256,
    parameter int unsigned CNT_W      = $clog2(TOTAL_BITS + 1)
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic [7:0]       byte_data,
    output logic             prog_enable,
    output logic             prog_data,
    output logic             hold,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] bit_count
);

    localparam logic [CNT_W-1:0] TotalCnt = CNT_W'(TOTAL_BITS);

    typedef enum logic [2:0] {
        StIdle,
        StWaitByte,
        StShift,
        StWaitCsum,
        StDone,
        StError
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       csum_q, csum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       nleft_q, nleft_d;
    logic [31:0]      remain;

    // Bits still owed to instruction memory; the last byte may be partial.
    assign remain = TOTAL_BITS - 32'(cnt_q);

    // State and datapath registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shreg_q <= '0;
            csum_q  <= '0;
            cnt_q   <= '0;
            nleft_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            csum_q  <= csum_d;
            cnt_q   <= cnt_d;
            nleft_q <= nleft_d;
        end
    end

    // Next-state logic and handshake/serial outputs.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        csum_d      = csum_q;
        cnt_d       = cnt_q;
        nleft_d     = nleft_q;
        byte_ready  = 1'b0;
        prog_enable = 1'b0;
        prog_data   = 1'b0;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d = StWaitByte;
                    cnt_d   = '0;
                    csum_d  = '0;
                end
            end
            StWaitByte: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    shreg_d = byte_data;
                    // Discarded upper bits of a partial byte still count in the checksum.
                    csum_d  = csum_q ^ byte_data;
                    nleft_d = (remain >= 32'd8) ? 4'd8 : remain[3:0];
                    state_d = StShift;
                end
            end
            StShift: begin
                prog_enable = 1'b1;
                prog_data   = shreg_q[0];
                shreg_d     = {1'b0, shreg_q[7:1]};
                cnt_d       = cnt_q + CNT_W'(1);
                nleft_d     = nleft_q - 4'd1;
                if (nleft_q == 4'd1) begin
                    state_d = (cnt_q + CNT_W'(1) == TotalCnt) ? StWaitCsum : StWaitByte;
                end
            end
            StWaitCsum: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_d = (byte_data == csum_q) ? StDone : StError;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Status flags decode directly from state so reset clears them immediately.
    assign busy      = (state_q == StWaitByte) || (state_q == StShift) || (state_q == StWaitCsum);
    assign hold      = busy || (state_q == StError);
    assign done      = (state_q == StDone);
    assign error     = (state_q == StError);
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboard of expected program bits
// for a TOTAL_BITS=20 instance plus a TOTAL_BITS=8 instance.
module tb_prog_loader;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    logic       a_start = 1'b0, a_valid = 1'b0;
    logic [7:0] a_data = 8'h00;
    logic       a_ready, a_en, a_pd, a_hold, a_busy, a_done, a_err;
    logic [4:0] a_cnt;

    logic       b_start = 1'b0, b_valid = 1'b0;
    logic [7:0] b_data = 8'h00;
    logic       b_ready, b_en, b_pd, b_hold, b_busy, b_done, b_err;
    logic [3:0] b_cnt;

    prog_loader #(.TOTAL_BITS(20)) dut_a (
        .clock(clock), .rst_n(rst_n), .start(a_start), .byte_valid(a_valid),
        .byte_ready(a_ready), .byte_data(a_data), .prog_enable(a_en), .prog_data(a_pd),
        .hold(a_hold), .busy(a_busy), .done(a_done), .error(a_err), .bit_count(a_cnt)
    );

    prog_loader #(.TOTAL_BITS(8)) dut_b (
        .clock(clock), .rst_n(rst_n), .start(b_start), .byte_valid(b_valid),
        .byte_ready(b_ready), .byte_data(b_data), .prog_enable(b_en), .prog_data(b_pd),
        .hold(b_hold), .busy(b_busy), .done(b_done), .error(b_err), .bit_count(b_cnt)
    );

    int n_checks = 0;
    int n_fail = 0;
    int hs_count = 0;
    logic exp_q[$];
    logic qb[$];
    logic [4:0] bits_seen = 5'd0;
    logic [7:0] prog_bytes [3] = '{8'hA5, 8'h3C, 8'h0F};
    int prog_nbits [3] = '{8, 8, 4};

    // Scoreboard monitor for dut_a: every enabled bit must match the next expected bit.
    always @(negedge clock) begin
        if (rst_n) begin
            if (a_valid && a_ready) hs_count++;
            if (a_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_bit: prog_enable with no expected bit, bit_count=%0d", a_cnt);
                end else begin
                    logic e;
                    e = exp_q.pop_front();
                    if (a_pd !== e || a_cnt !== bits_seen) begin
                        n_fail++;
                        $display("FAIL prog_bit: data=%b cnt=%0d, expected data=%b cnt=%0d",
                                 a_pd, a_cnt, e, bits_seen);
                    end
                end
                bits_seen++;
                if (a_ready || !a_busy) begin
                    n_fail++;
                    $display("FAIL enable_outside_shift: ready=%b busy=%b", a_ready, a_busy);
                end
            end
        end
    end

    task automatic start_a;
        @(posedge clock); #1;
        a_start = 1'b1;
        @(posedge clock); #1;
        a_start = 1'b0;
        bits_seen = 5'd0;
        hs_count = 0;
    endtask

    // Offer one byte after a gap; push its expected bits when the handshake is seen.
    task automatic send_a(input logic [7:0] d, input int nbits, input int gap);
        bit ok;
        ok = 1'b0;
        for (int g = 0; g < gap; g++) begin
            a_data = 8'($urandom);
            @(posedge clock); #1;
        end
        a_valid = 1'b1;
        a_data  = d;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clock);
            if (a_ready) begin
                ok = 1'b1;
                for (int j = 0; j < nbits; j++) exp_q.push_back(d[j]);
            end
            @(posedge clock); #1;
        end
        a_valid = 1'b0;
        a_data  = 8'($urandom);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL handshake_timeout: byte %h not accepted, expected acceptance", d);
        end
    endtask

    task automatic run_load_a(input logic [7:0] csum, input int maxgap);
        for (int i = 0; i < 3; i++) send_a(prog_bytes[i], prog_nbits[i], $urandom_range(0, maxgap));
        send_a(csum, 0, $urandom_range(0, maxgap));
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if ({a_ready, a_en, a_pd, a_hold, a_busy, a_done, a_err, a_cnt} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_a: outputs=%b, expected all 0",
                     {a_ready, a_en, a_pd, a_hold, a_busy, a_done, a_err, a_cnt});
        end
        n_checks++;
        if ({b_ready, b_en, b_pd, b_hold, b_busy, b_done, b_err, b_cnt} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_b: outputs=%b, expected all 0",
                     {b_ready, b_en, b_pd, b_hold, b_busy, b_done, b_err, b_cnt});
        end
        @(posedge clock); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_good_load;
        start_a();
        @(negedge clock);
        n_checks++;
        if ({a_done, a_err, a_hold, a_busy} !== 4'b0011 || a_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL good_start: d/e/h/b=%b cnt=%0d, expected 0011 cnt=0",
                     {a_done, a_err, a_hold, a_busy}, a_cnt);
        end
        @(posedge clock); #1;
        run_load_a(8'h96, 0);
        @(negedge clock);
        n_checks++;
        if ({a_done, a_err, a_hold, a_busy} !== 4'b1000 || a_cnt !== 5'd20) begin
            n_fail++;
            $display("FAIL good_done: d/e/h/b=%b cnt=%0d, expected 1000 cnt=20",
                     {a_done, a_err, a_hold, a_busy}, a_cnt);
        end
        n_checks++;
        if (bits_seen !== 5'd20 || exp_q.size() != 0 || hs_count != 4) begin
            n_fail++;
            $display("FAIL good_counts: bits=%0d left=%0d bytes=%0d, expected 20 0 4",
                     bits_seen, exp_q.size(), hs_count);
        end
    endtask

    task automatic test_bad_checksum;
        start_a();
        run_load_a(8'h97, 0);
        @(negedge clock);
        n_checks++;
        if ({a_done, a_err, a_hold, a_busy} !== 4'b0110 || a_cnt !== 5'd20) begin
            n_fail++;
            $display("FAIL bad_csum: d/e/h/b=%b cnt=%0d, expected 0110 cnt=20",
                     {a_done, a_err, a_hold, a_busy}, a_cnt);
        end
        start_a();
        @(negedge clock);
        n_checks++;
        if ({a_done, a_err, a_hold, a_busy} !== 4'b0011 || a_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL restart_clear: d/e/h/b=%b cnt=%0d, expected 0011 cnt=0",
                     {a_done, a_err, a_hold, a_busy}, a_cnt);
        end
        @(posedge clock); #1;
        run_load_a(8'h96, 0);
        @(negedge clock);
        n_checks++;
        if ({a_done, a_err, a_hold, a_busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL recover_done: d/e/h/b=%b, expected 1000", {a_done, a_err, a_hold, a_busy});
        end
    endtask

    task automatic test_random_gaps;
        for (int r = 0; r < 3; r++) begin
            start_a();
            run_load_a(8'h96, 4);
            @(negedge clock);
            n_checks++;
            if (a_done !== 1'b1 || bits_seen !== 5'd20 || exp_q.size() != 0 || hs_count != 4) begin
                n_fail++;
                $display("FAIL gaps_load: done=%b bits=%0d left=%0d bytes=%0d, expected 1 20 0 4",
                         a_done, bits_seen, exp_q.size(), hs_count);
            end
        end
    endtask

    task automatic test_start_ignored;
        bit ok;
        start_a();
        send_a(prog_bytes[0], 8, 0);
        a_start = 1'b1;              // lands mid-shift
        @(posedge clock); #1;
        a_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (a_ready) ok = 1'b1;
        end
        a_start = 1'b1;              // lands in the byte wait
        @(posedge clock); #1;
        a_start = 1'b0;
        @(negedge clock);
        n_checks++;
        if (!ok || a_cnt !== 5'd8 || a_busy !== 1'b1 || a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ignored: ok=%b cnt=%0d busy=%b ready=%b, expected 1 8 1 1",
                     ok, a_cnt, a_busy, a_ready);
        end
        @(posedge clock); #1;
        send_a(prog_bytes[1], 8, 0);
        send_a(prog_bytes[2], 4, 0);
        send_a(8'h96, 0, 0);
        @(negedge clock);
        n_checks++;
        if (a_done !== 1'b1 || bits_seen !== 5'd20 || a_cnt !== 5'd20) begin
            n_fail++;
            $display("FAIL ignored_done: done=%b bits=%0d cnt=%0d, expected 1 20 20",
                     a_done, bits_seen, a_cnt);
        end
    endtask

    task automatic test_async_reset;
        bit ok;
        start_a();
        send_a(prog_bytes[0], 8, 0);
        send_a(prog_bytes[1], 8, 0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (a_en && a_cnt == 5'd11) ok = 1'b1;
        end
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_checks++;
        if (!ok || {a_ready, a_en, a_pd, a_hold, a_busy, a_done, a_err, a_cnt} !== 12'd0) begin
            n_fail++;
            $display("FAIL async_reset: reached=%b outputs=%b, expected 1 and all 0", ok,
                     {a_ready, a_en, a_pd, a_hold, a_busy, a_done, a_err, a_cnt});
        end
        @(posedge clock); #1;
        rst_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({a_ready, a_hold, a_busy, a_done, a_err} !== 5'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: r/h/b/d/e=%b, expected 00000",
                     {a_ready, a_hold, a_busy, a_done, a_err});
        end
        start_a();
        run_load_a(8'h96, 2);
        @(negedge clock);
        n_checks++;
        if (a_done !== 1'b1 || bits_seen !== 5'd20) begin
            n_fail++;
            $display("FAIL reload_done: done=%b bits=%0d, expected 1 20", a_done, bits_seen);
        end
    endtask

    task automatic test_single_byte_b;
        bit ok;
        int en_cnt;
        logic e;
        @(posedge clock); #1;
        b_start = 1'b1;
        @(posedge clock); #1;
        b_start = 1'b0;
        b_valid = 1'b1;
        b_data  = 8'hFF;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clock);
            if (b_ready) begin
                ok = 1'b1;
                repeat (8) qb.push_back(1'b1);
            end
            @(posedge clock); #1;
        end
        b_valid = 1'b0;
        b_data  = 8'h00;
        en_cnt = 0;
        for (int i = 0; i < 20 && ok; i++) begin
            @(negedge clock);
            if (b_en) begin
                en_cnt++;
                e = (qb.size() != 0) ? qb.pop_front() : 1'bx;
                n_checks++;
                if (b_pd !== e) begin
                    n_fail++;
                    $display("FAIL b_bit: data=%b, expected %b", b_pd, e);
                end
            end
            if (b_ready) break;
        end
        n_checks++;
        if (!ok || en_cnt != 8 || b_cnt !== 4'd8 || b_busy !== 1'b1 || b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b_shift: ok=%b enables=%0d cnt=%0d busy=%b ready=%b, expected 1 8 8 1 1",
                     ok, en_cnt, b_cnt, b_busy, b_ready);
        end
        b_valid = 1'b1;
        b_data  = 8'hFF;
        @(posedge clock); #1;
        b_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({b_done, b_err, b_hold, b_busy} !== 4'b1000 || b_cnt !== 4'd8) begin
            n_fail++;
            $display("FAIL b_done: d/e/h/b=%b cnt=%0d, expected 1000 cnt=8",
                     {b_done, b_err, b_hold, b_busy}, b_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_random_gaps();
        test_start_ignored();
        test_async_reset();
        test_single_byte_b();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
